counter_ctrl_unit: RTL and testbench

- Upstream data source for the 4-digit FND display path: owns a run/stop/clear FSM, a tick prescaler and a decimal up/down counter (0..MAX_COUNT).
- Drives a 14-bit binary count to the FND controller, which splits it into digits and scans fnd_com/fnd_data.
- Button inputs arrive already debounced and synchronised to clk. This block only edge-detects them.

---
 rtl/counter_ctrl_unit_pkg.sv | 30 +++
 rtl/counter_ctrl_unit_tick_gen.sv | 35 +++
 rtl/counter_ctrl_unit.sv | 112 +++++++++++
 tb/tb_counter_ctrl_unit.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/counter_ctrl_unit_pkg.sv
// Shared definitions for the counter control unit: FSM encoding, count width,
// default parameters and the wrap-aware count step helper.
package counter_ctrl_unit_pkg;

  localparam int CNT_W         = 14;
  localparam int DEF_MAX_COUNT = 9999;
  localparam int DEF_TICK_DIV  = 10_000_000;

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CLEAR = 2'd2
  } state_e;

  // One count step in the selected direction, wrapping between 0 and max_c.
  function automatic logic [CNT_W-1:0] step_count(
    input logic [CNT_W-1:0] cnt,
    input logic             down,
    input logic [CNT_W-1:0] max_c
  );
    logic [CNT_W-1:0] nxt;
    if (down) begin
      nxt = (cnt == '0) ? max_c : cnt - CNT_W'(1);
    end else begin
      nxt = (cnt == max_c) ? '0 : cnt + CNT_W'(1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/counter_ctrl_unit_tick_gen.sv
// Prescaler: counts 0..TICK_DIV-1 while enabled, holds while disabled, and
// emits a one-cycle tick in the cycle it is about to wrap.
module counter_ctrl_unit_tick_gen
  import counter_ctrl_unit_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int            W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0]  LAST = W'(TICK_DIV - 1);

  logic [W-1:0] cnt_q;

  assign tick_o = en_i && (cnt_q == LAST);

  // Prescaler register: clear has priority over counting, wraps on tick.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking '<=' so every register samples
    // pre-edge values; blocking '=' here would create order-dependent races.
    if (!reset) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= tick_o ? '0 : cnt_q + W'(1);
    end
  end

endmodule

// File: rtl/counter_ctrl_unit.sv
// Run/stop/clear controller with button edge detection and a wrapping
// up/down counter feeding the FND display path.
module counter_ctrl_unit
  import counter_ctrl_unit_pkg::*;
#(
  parameter int TICK_DIV  = DEF_TICK_DIV,
  parameter int MAX_COUNT = DEF_MAX_COUNT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_btn_run,
  input  logic             i_btn_clear,
  input  logic             i_btn_mode,
  output logic [CNT_W-1:0] o_count,
  output logic             o_tick,
  output logic             o_run,
  output logic             o_mode_down
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_COUNT);

  state_e           state_q;
  logic             prev_run_q, prev_clear_q, prev_mode_q;
  logic             rise_run, rise_clear, rise_mode;
  logic             tick;
  logic [CNT_W-1:0] count_q;
  logic             tick_q, run_q, mode_q;

  assign rise_run   = i_btn_run   & ~prev_run_q;
  assign rise_clear = i_btn_clear & ~prev_clear_q;
  assign rise_mode  = i_btn_mode  & ~prev_mode_q;

  counter_ctrl_unit_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk    (clk),
    .reset  (reset),
    .en_i   (state_q == ST_RUN),
    .clr_i  (state_q == ST_CLEAR),
    .tick_o (tick)
  );

  // Previous button levels, so a held button yields exactly one event.
  always_ff @(posedge clk) begin
    if (!reset) begin
      prev_run_q   <= 1'b0;
      prev_clear_q <= 1'b0;
      prev_mode_q  <= 1'b0;
    end else begin
      prev_run_q   <= i_btn_run;
      prev_clear_q <= i_btn_clear;
      prev_mode_q  <= i_btn_mode;
    end
  end

  // FSM, count, direction and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_STOP;
      run_q   <= 1'b0;
      count_q <= '0;
      tick_q  <= 1'b0;
      mode_q  <= 1'b0;
    end else begin
      tick_q <= tick;

      // A step uses the direction held before any toggle on this edge.
      if (state_q == ST_CLEAR) begin
        count_q <= '0;
      end else if (tick) begin
        count_q <= step_count(count_q, mode_q, MAX_C);
      end

      if (rise_mode) begin
        mode_q <= ~mode_q;
      end

      case (state_q)
        ST_STOP: begin
          if (rise_clear) begin
            state_q <= ST_CLEAR;
            run_q   <= 1'b0;
          end else if (rise_run) begin
            state_q <= ST_RUN;
            run_q   <= 1'b1;
          end
        end
        ST_RUN: begin
          // Clear is deliberately ignored while running.
          if (rise_run) begin
            state_q <= ST_STOP;
            run_q   <= 1'b0;
          end
        end
        ST_CLEAR: begin
          state_q <= ST_STOP;
          run_q   <= 1'b0;
        end
        default: begin
          state_q <= ST_STOP;
          run_q   <= 1'b0;
        end
      endcase
    end
  end

  assign o_count     = count_q;
  assign o_tick      = tick_q;
  assign o_run       = run_q;
  assign o_mode_down = mode_q;

endmodule

// File: tb/tb_counter_ctrl_unit.sv
// Self-checking bench for counter_ctrl_unit: directed scenarios followed by
// random button/reset activity, all compared cycle by cycle to a behavioural model.
module tb_counter_ctrl_unit;

  localparam int TD = 10;
  localparam int MC = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        btn_run = 1'b0, btn_clear = 1'b0, btn_mode = 1'b0;
  logic [13:0] o_count;
  logic        o_tick, o_run, o_mode_down;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  bit m_running, m_clearing, m_down, m_tick;
  bit p_run, p_clear, p_mode;
  int m_count, m_phase;

  counter_ctrl_unit #(
    .TICK_DIV  (TD),
    .MAX_COUNT (MC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .i_btn_run   (btn_run),
    .i_btn_clear (btn_clear),
    .i_btn_mode  (btn_mode),
    .o_count     (o_count),
    .o_tick      (o_tick),
    .o_run       (o_run),
    .o_mode_down (o_mode_down)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    checks++;
    errors++;
    $error("FAIL %s: wait budget expired", tag);
  endtask

  // Model update for one rising edge, given the inputs present before it.
  task automatic model_step(input bit rst, input bit r, input bit c, input bit m);
    bit rr, rc, rm;
    if (!rst) begin
      m_running = 0; m_clearing = 0; m_down = 0; m_tick = 0;
      p_run = 0; p_clear = 0; p_mode = 0;
      m_count = 0; m_phase = 0;
      return;
    end
    rr = r && !p_run;
    rc = c && !p_clear;
    rm = m && !p_mode;
    p_run = r; p_clear = c; p_mode = m;
    m_tick = 0;
    if (m_clearing) begin
      m_count = 0;
      m_phase = 0;
      m_clearing = 0;
    end else if (m_running) begin
      m_phase = m_phase + 1;
      if (m_phase == TD) begin
        m_phase = 0;
        m_tick = 1;
        m_count = m_down ? (m_count + MC) % (MC + 1) : (m_count + 1) % (MC + 1);
      end
      if (rr) m_running = 0;
    end else begin
      if (rc) m_clearing = 1;
      else if (rr) m_running = 1;
    end
    if (rm) m_down = !m_down;
  endtask

  task automatic step(input bit rst, input bit r, input bit c, input bit m);
    reset = rst; btn_run = r; btn_clear = c; btn_mode = m;
    @(posedge clk);
    model_step(rst, r, c, m);
    #1;
    chk("model_count", o_count, m_count);
    chk("model_tick", o_tick, m_tick);
    chk("model_run", o_run, m_running);
    chk("model_mode", o_mode_down, m_down);
  endtask

  task automatic run_until_tick_value(input int v, input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      step(1, 0, 0, 0);
      if (m_tick && m_count == v) return;
    end
    timeout(tag);
  endtask

  initial begin
    int  guard;
    bit  lr, lc, lm, lrst;

    // Reset held two cycles, then idle: no ticks, everything zero.
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("reset_count", o_count, 0);
    chk("reset_run", o_run, 0);
    chk("reset_mode", o_mode_down, 0);
    repeat (100) step(1, 0, 0, 0);
    chk("idle_count", o_count, 0);

    // Run pulse of 3 cycles; count reaches 3 thirty cycles after entering RUN.
    step(1, 1, 0, 0);
    chk("run_on", o_run, 1);
    repeat (2) step(1, 1, 0, 0);
    repeat (28) step(1, 0, 0, 0);
    chk("count_3", o_count, 3);
    chk("tick_at_3", o_tick, 1);

    // Second run pulse stops; count frozen.
    repeat (3) step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    repeat (20) step(1, 0, 0, 0);
    chk("frozen_run", o_run, 0);
    chk("frozen_count", o_count, 3);

    // Run up to MAX_COUNT and wrap to 0.
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    run_until_tick_value(0, 400, "wait_wrap_up");
    chk("wrap_up", o_count, 0);
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    chk("stop_at_0", o_run, 0);

    // Toggle to down mode in STOP, then run: 0 wraps to MAX_COUNT.
    step(1, 0, 0, 1);
    step(1, 0, 0, 0);
    chk("mode_down", o_mode_down, 1);
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    run_until_tick_value(MC, 50, "wait_wrap_down");
    chk("wrap_down", o_count, MC);

    // Stop at 5, then run and clear rise together: clear wins.
    run_until_tick_value(5, 200, "wait_5");
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    chk("stop_at_5", o_count, 5);
    step(1, 1, 1, 0);
    step(1, 1, 1, 0);
    chk("clear_wins_count", o_count, 0);
    chk("clear_wins_run", o_run, 0);
    step(1, 0, 0, 0);

    // Back to up mode; clear ignored in RUN; run press on the tick edge.
    step(1, 0, 0, 1);
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    run_until_tick_value(7, 200, "wait_7");
    repeat (3) step(1, 0, 1, 0);
    step(1, 0, 0, 0);
    chk("clear_ignored_run", o_run, 1);
    run_until_tick_value(8, 40, "wait_8");
    chk("count_8", o_count, 8);
    guard = 0;
    while (!(m_running && m_phase == TD - 1) && guard < 2 * TD) begin
      step(1, 0, 0, 0);
      guard++;
    end
    if (guard >= 2 * TD) timeout("wait_pre_tick");
    step(1, 1, 0, 0);
    chk("tick_stop_count", o_count, 9);
    chk("tick_stop_run", o_run, 0);
    chk("tick_stop_tick", o_tick, 1);
    step(1, 0, 0, 0);

    // Clear, run to 4, then a mid-run reset.
    step(1, 0, 1, 0);
    step(1, 0, 0, 0);
    chk("cleared", o_count, 0);
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    run_until_tick_value(4, 100, "wait_4");
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("midrun_reset_count", o_count, 0);
    chk("midrun_reset_run", o_run, 0);
    chk("midrun_reset_mode", o_mode_down, 0);

    // Fresh run: first tick exactly TD cycles after entering RUN.
    step(1, 1, 0, 0);
    for (int i = 0; i < TD - 1; i++) begin
      step(1, 0, 0, 0);
      chk("no_early_tick", o_tick, 0);
    end
    step(1, 0, 0, 0);
    chk("first_tick", o_tick, 1);
    chk("first_tick_count", o_count, 1);

    // Random button levels with occasional resets.
    lr = 0; lc = 0; lm = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) lr = !lr;
      if ($urandom_range(0, 15) == 0) lc = !lc;
      if ($urandom_range(0, 23) == 0) lm = !lm;
      lrst = ($urandom_range(0, 299) != 0);
      step(lrst, lr, lc, lm);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
